ipu_pad_ctrl: RTL and testbench

Control stage of the SHA-2 input processing unit. It sits directly upstream of the packet mux in the IPU data path. It accepts the message as a stream of w-bit words and drives the mux selects (pad, zero, message-length). It also drives a running bit-length value and per-word valid and block-boundary strobes, so that the mux output forms correctly padded 16-word SHA-2 blocks.

---
 rtl/ipu_pad_ctrl_pkg.sv | 17 +
 rtl/ipu_pad_ctrl_if.sv | 29 ++
 rtl/ipu_pad_ctrl.sv | 110 +++++++++++
 tb/tb_ipu_pad_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ipu_pad_ctrl_pkg.sv
// Shared IPU control definitions: padder FSM states and SHA-2 block layout indices.
package ipu_pad_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MSG,
    ST_PAD,
    ST_ZERO,
    ST_LEN
  } state_t;

  localparam int BLK_WORDS    = 16;
  localparam int LEN_HI_IDX   = 14;
  localparam int LEN_LO_IDX   = 15;
  localparam int LAST_PAD_IDX = 13;

endpackage

// File: rtl/ipu_pad_ctrl_if.sv
// Handshake, mux-select and strobe bundle between the message source, padder control and packet mux.
interface ipu_pad_ctrl_if #(
  parameter int W = 64
);

  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         out_ready;
  logic         out_valid;
  logic         pad_pkt;
  logic         zero_pkt;
  logic         mgln_pkt;
  logic [W-1:0] msg_len;
  logic         blk_start;
  logic         blk_end;
  logic         done;

  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, out_valid, pad_pkt, zero_pkt, mgln_pkt, msg_len, blk_start, blk_end, done
  );

  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, out_valid, pad_pkt, zero_pkt, mgln_pkt, msg_len, blk_start, blk_end, done
  );

endinterface

// File: rtl/ipu_pad_ctrl.sv
// SHA-2 padding control: steers the packet mux to emit message, pad, zero and length words as 16-word blocks.
// Zero-latency selects decoded from registered state/idx; out_ready low freezes everything, in_ready=0 while padding.
module ipu_pad_ctrl #(
  parameter int W         = 64,
  parameter int BLK_WORDS = ipu_pad_ctrl_pkg::BLK_WORDS
) (
  input logic           clk,
  input logic           rst_b,
  ipu_pad_ctrl_if.slave io
);

  import ipu_pad_ctrl_pkg::*;

  localparam int IDX_W = $clog2(BLK_WORDS);
  localparam logic [IDX_W-1:0] HI_IDX  = IDX_W'(LEN_HI_IDX);
  localparam logic [IDX_W-1:0] LO_IDX  = IDX_W'(LEN_LO_IDX);
  localparam logic [IDX_W-1:0] PAD_IDX = IDX_W'(LAST_PAD_IDX);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     msg_len;
  logic             len_ahead;
  logic             done_q;

  logic             rdy;
  logic             vld;
  logic             sel_pad;
  logic             sel_zero;
  logic             sel_len;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    vld       = 1'b0;
    sel_pad   = 1'b0;
    sel_zero  = 1'b0;
    sel_len   = 1'b0;
    unique case (state)
      ST_IDLE, ST_MSG: begin
        rdy = io.out_ready;
        vld = io.in_valid;
        if (io.in_valid && io.out_ready) begin
          state_nxt = io.in_last ? ST_PAD : ST_MSG;
        end
      end
      ST_PAD: begin
        sel_pad = 1'b1;
        vld     = 1'b1;
        if (io.out_ready) state_nxt = ST_ZERO;
      end
      ST_ZERO: begin
        sel_zero = 1'b1;
        vld      = 1'b1;
        if (io.out_ready && (idx == HI_IDX) && !len_ahead) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        sel_len = 1'b1;
        vld     = 1'b1;
        if (io.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign xfer = vld & io.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      idx       <= '0;
      msg_len   <= '0;
      len_ahead <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= xfer && (state == ST_LEN);
      if (xfer) begin
        idx <= (state == ST_LEN) ? '0 : idx + IDX_W'(1);
        unique case (state)
          ST_IDLE, ST_MSG: msg_len <= msg_len + W'(W);
          // Pad at idx 14 leaves no room for the length field in this block;
          // a pad at idx 15 already wraps into the length block on this transfer.
          ST_PAD:  len_ahead <= (idx > PAD_IDX) && (idx != LO_IDX);
          ST_ZERO: if (idx == LO_IDX) len_ahead <= 1'b0;
          ST_LEN:  msg_len <= '0;
          default: ;
        endcase
      end
    end
  end

  assign io.in_ready  = rdy;
  assign io.out_valid = vld;
  assign io.pad_pkt   = sel_pad;
  assign io.zero_pkt  = sel_zero;
  assign io.mgln_pkt  = sel_len;
  assign io.msg_len   = msg_len;
  assign io.blk_start = vld & (idx == '0);
  assign io.blk_end   = vld & (idx == LO_IDX);
  assign io.done      = done_q;

endmodule

// File: tb/tb_ipu_pad_ctrl.sv
// Bench for ipu_pad_ctrl: directed messages with a reference padding model feeding a scoreboard of expected mux words.
module tb_ipu_pad_ctrl;

  localparam int W = 64;
  localparam logic [2:0] S_DATA = 3'b000;
  localparam logic [2:0] S_PAD  = 3'b100;
  localparam logic [2:0] S_ZERO = 3'b010;
  localparam logic [2:0] S_LEN  = 3'b001;

  typedef struct packed {
    logic [2:0]   sel;
    logic [3:0]   idx;
    logic [W-1:0] word;
    logic [W-1:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  ipu_pad_ctrl_if #(.W(W)) io ();
  logic [W-1:0] pkt;
  logic [W-1:0] mux_out;

  ipu_pad_ctrl #(.W(W), .BLK_WORDS(16)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .io    (io)
  );

  // Downstream packet mux as the IPU data path would build it.
  always_comb begin
    mux_out = pkt;
    if (io.pad_pkt)       mux_out = {1'b1, {(W-1){1'b0}}};
    else if (io.zero_pkt) mux_out = '0;
    else if (io.mgln_pkt) mux_out = io.msg_len;
  end

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           done_cnt = 0;
  bit           done_pend = 1'b0;
  bit           stall_en = 1'b0;
  logic [3:0]   m_idx;
  logic [W-1:0] m_len;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_trailer();
    logic [3:0] p;
    p = m_idx;
    sb.push_back(exp_t'{S_PAD, m_idx, {1'b1, {(W-1){1'b0}}}, m_len});
    m_idx++;
    if (p > 4'd13) begin
      while (m_idx != 4'd0) begin
        sb.push_back(exp_t'{S_ZERO, m_idx, {W{1'b0}}, m_len});
        m_idx++;
      end
    end
    while (m_idx != 4'd15) begin
      sb.push_back(exp_t'{S_ZERO, m_idx, {W{1'b0}}, m_len});
      m_idx++;
    end
    sb.push_back(exp_t'{S_LEN, m_idx, m_len, m_len});
    m_idx = 4'd0;
    m_len = '0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit last);
    int guard;
    bit acc;
    guard = 0;
    acc = 1'b0;
    if (stall_en && $urandom_range(0, 2) == 0) begin
      @(posedge clk);
      #1;
    end
    pkt = d;
    io.in_valid = 1'b1;
    io.in_last = last;
    sb.push_back(exp_t'{S_DATA, m_idx, d, m_len});
    do begin
      @(negedge clk);
      acc = io.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL word_accept_timeout observed=%0d expected=1", acc);
    end
    m_idx++;
    m_len = m_len + W;
    io.in_valid = 1'b0;
    io.in_last = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit fixed_first);
    int start;
    int guard;
    for (int k = 0; k < n; k++) begin
      send_word((k == 0 && fixed_first) ? 64'hDEADBEEF_00000000 : {$urandom, $urandom}, k == n - 1);
    end
    push_trailer();
    start = done_cnt;
    guard = 0;
    while (done_cnt == start && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    assert (done_cnt != start) else begin
      failures++;
      $error("FAIL done_timeout observed=%0d expected=%0d", done_cnt, start + 1);
    end
    chk("sb_drained", W'(sb.size()), '0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      io.out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_b) begin
      chk("done", W'(io.done), W'(done_pend));
      if (io.done === 1'b1) done_cnt++;
      done_pend = 1'b0;
      if (io.pad_pkt | io.zero_pkt | io.mgln_pkt) chk("in_ready_trailer", W'(io.in_ready), '0);
      if (io.out_valid && io.out_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_word observed=%h expected=none", mux_out);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sel", W'({io.pad_pkt, io.zero_pkt, io.mgln_pkt}), W'(e.sel));
          chk("word", mux_out, e.word);
          chk("msg_len", io.msg_len, e.len);
          chk("blk_start", W'(io.blk_start), W'(e.idx == 4'd0));
          chk("blk_end", W'(io.blk_end), W'(e.idx == 4'd15));
          if (e.sel == S_DATA) chk("in_ready_msg", W'(io.in_ready), W'(1));
          if (e.sel == S_LEN) done_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    io.in_valid = 1'b0;
    io.in_last = 1'b0;
    io.out_ready = 1'b1;
    pkt = '0;
    m_idx = 4'd0;
    m_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_msg_len", io.msg_len, '0);
    chk("rst_sel", W'({io.pad_pkt, io.zero_pkt, io.mgln_pkt}), '0);
    chk("rst_done", W'(io.done), '0);
    chk("rst_out_valid", W'(io.out_valid), '0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    send_msg(1, 1'b1);
    send_msg(13, 1'b0);
    send_msg(14, 1'b0);
    send_msg(16, 1'b0);
    send_msg(15, 1'b0);

    stall_en = 1'b1;
    send_msg(1, 1'b1);
    send_msg(13, 1'b0);
    send_msg(14, 1'b0);
    send_msg(16, 1'b0);
    send_msg(20, 1'b0);
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    // Abort mid-message: reset lands on word 5.
    for (int k = 0; k < 5; k++) send_word({$urandom, $urandom}, 1'b0);
    pkt = {$urandom, $urandom};
    io.in_valid = 1'b1;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    io.in_valid = 1'b0;
    sb.delete();
    m_idx = 4'd0;
    m_len = '0;
    @(negedge clk);
    chk("abort_msg_len", io.msg_len, '0);
    chk("abort_sel", W'({io.pad_pkt, io.zero_pkt, io.mgln_pkt}), '0);
    chk("abort_out_valid", W'(io.out_valid), '0);
    @(posedge clk);
    #1;
    send_msg(1, 1'b1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
